// File: rtl/pipeline_fifo.sv
// Elastic buffer between `pipeline` and a slow consumer: level-DIR / pulsed-ack
// capture on the input side, DOR / ack_to_fifo pop on the output side.
module pipeline_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 DIR,
  output logic                 ack_from_fifo,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 DOR,
  input  logic                 ack_to_fifo,
  output logic [WIDTH-1:0]     data_out,
  output logic [ADDR_BITS:0]   count,
  output logic                 underflow,
  output logic                 in_state_dbg
);

  // Handshake semantics:
  //   input:  DIR is a level held with data_in until acked. A word is taken on
  //           the first edge where the input FSM is ARMED, DIR=1 and the
  //           pre-edge count is below DEPTH; ack_from_fifo pulses for the one
  //           cycle after that edge. DIR must drop before the next word counts.
  //   output: DOR=1 while any word is stored and data_out is the head. Every
  //           edge with ack_to_fifo=1 and DOR=1 pops exactly one word; an ack
  //           with DOR=0 pops nothing and sets the sticky underflow flag.

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } in_state_t;

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  in_state_t            state;
  in_state_t            state_next;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Input FSM: next state and the push decision.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ARMED: begin
        if (DIR && !full) begin
          push       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!DIR) begin
          state_next = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
  end

  assign pop = ack_to_fifo && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // Storage is not reset; count=0 masks whatever is left behind.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ack_from_fifo <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      ack_from_fifo <= push;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (ack_to_fifo && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign DOR          = !empty;
  assign data_out     = empty ? '0 : mem[rd_ptr];
  assign in_state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= FULL_COUNT)
        else $error("pipeline_fifo: count above DEPTH");
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Directed bench for pipeline_fifo: capture, stall-on-full, wrap, simultaneous
// push/pop, underflow and mid-transfer reset.
module tb_pipeline_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int ADDR_BITS = 2;

  logic                 clk;
  logic                 reset;
  logic                 DIR;
  logic                 ack_from_fifo;
  logic [WIDTH-1:0]     data_in;
  logic                 DOR;
  logic                 ack_to_fifo;
  logic [WIDTH-1:0]     data_out;
  logic [ADDR_BITS:0]   count;
  logic                 underflow;
  logic                 in_state_dbg;

  logic [WIDTH-1:0] exp_q[$];
  int n_checks;
  int n_errors;
  int ack_pulses;

  pipeline_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .DIR          (DIR),
    .ack_from_fifo(ack_from_fifo),
    .data_in      (data_in),
    .DOR          (DOR),
    .ack_to_fifo  (ack_to_fifo),
    .data_out     (data_out),
    .count        (count),
    .underflow    (underflow),
    .in_state_dbg (in_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic push_word(input logic [WIDTH-1:0] v);
    DIR     = 1'b1;
    data_in = v;
    tick();
    check("push_ack", ack_from_fifo, 1);
    exp_q.push_back(v);
    DIR = 1'b0;
    tick();
    check("push_ack_drop", ack_from_fifo, 0);
  endtask

  task automatic pop_word();
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL pop_scoreboard: got empty queue expected a word");
    end else begin
      e = exp_q.pop_front();
      check("pop_dor", DOR, 1);
      check("pop_data", data_out, e);
      ack_to_fifo = 1'b1;
      tick();
      ack_to_fifo = 1'b0;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    DIR         = 1'b0;
    data_in     = '0;
    ack_to_fifo = 1'b0;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_dor", DOR, 0);
    check("rst_data", data_out, 0);
    check("rst_ack", ack_from_fifo, 0);
    check("rst_underflow", underflow, 0);
    check("rst_state", in_state_dbg, 0);
    reset = 1'b0;
    tick();

    // DIR held for 3 cycles yields one capture.
    ack_pulses = 0;
    DIR = 1'b1;
    data_in = 8'd42;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack_from_fifo) ack_pulses++;
    end
    DIR = 1'b0;
    tick();
    if (ack_from_fifo) ack_pulses++;
    check("hold_one_ack", ack_pulses, 1);
    check("hold_dor", DOR, 1);
    check("hold_data", data_out, 42);
    check("hold_count", count, 1);
    ack_to_fifo = 1'b1;
    tick();
    ack_to_fifo = 1'b0;
    check("single_pop_dor", DOR, 0);
    check("single_pop_data", data_out, 0);
    check("single_pop_count", count, 0);

    // Fill, then stall with DIR held until one pop frees a slot.
    for (int i = 10; i <= 13; i++) push_word(WIDTH'(i));
    check("full_count", count, 4);
    DIR = 1'b1;
    data_in = 8'd14;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_ack", ack_from_fifo, 0);
      check("full_count_held", count, 4);
    end
    ack_to_fifo = 1'b1;
    void'(exp_q.pop_front());
    tick();
    ack_to_fifo = 1'b0;
    check("full_pop_stall_ack", ack_from_fifo, 0);
    check("full_pop_count", count, 3);
    check("full_pop_head", data_out, 11);
    tick();
    check("late_capture_ack", ack_from_fifo, 1);
    check("late_capture_count", count, 4);
    exp_q.push_back(8'd14);
    DIR = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pop_word();
    check("drain_count", count, 0);

    // Interleaved pushes and pops wrap the pointers.
    for (int i = 0; i < 7; i++) begin
      push_word(WIDTH'(20 + i));
      if (i % 2 == 1) pop_word();
      check("wrap_count_max", (count <= 4) ? 1 : 0, 1);
    end
    check("wrap_count", count, 4);
    for (int i = 0; i < 4; i++) pop_word();
    check("wrap_empty", DOR, 0);

    // Push and pop in the same edge at count=1.
    push_word(8'd5);
    DIR = 1'b1;
    data_in = 8'd6;
    ack_to_fifo = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(8'd6);
    tick();
    ack_to_fifo = 1'b0;
    check("simul_count", count, 1);
    check("simul_data", data_out, 6);
    check("simul_ack", ack_from_fifo, 1);
    DIR = 1'b0;
    tick();
    pop_word();

    // Ack while empty sets a sticky underflow.
    ack_to_fifo = 1'b1;
    tick();
    ack_to_fifo = 1'b0;
    check("uf_set", underflow, 1);
    check("uf_count", count, 0);
    check("uf_dor", DOR, 0);
    push_word(8'd33);
    pop_word();
    check("uf_sticky", underflow, 1);

    // Reset with count=3 and the input FSM in HOLD, DIR still high.
    push_word(8'd1);
    push_word(8'd2);
    DIR = 1'b1;
    data_in = 8'd3;
    tick();
    check("pre_rst_count", count, 3);
    check("pre_rst_state", in_state_dbg, 1);
    data_in = 8'd99;
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_dor", DOR, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_ack", ack_from_fifo, 0);
    check("mid_rst_underflow", underflow, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ack", ack_from_fifo, 1);
    check("post_rst_count", count, 1);
    check("post_rst_data", data_out, 99);
    exp_q.push_back(8'd99);
    DIR = 1'b0;
    tick();
    pop_word();
    check("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_fifo.md
# pipeline_fifo

Elastic buffer stage that sits directly downstream of `pipeline`. It accepts words over the level-DIR / pulsed-ack handshake that `pipeline` and its consumers use, stores up to DEPTH words, and re-presents them on the DOR / ack handshake. It decouples a bursty producer from a slow consumer.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 4, number of storage entries; must be a power of two, at least 2
- ADDR_BITS, 2, log2(DEPTH)

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- DIR  in  1  upstream data-input-ready; level, held with data_in until the word is acked
- ack_from_fifo  out  1  one-cycle pulse: the word on data_in was captured
- data_in  in  WIDTH  upstream word
- DOR  out  1  data-output-ready; high while at least one word is stored
- ack_to_fifo  in  1  downstream ack; each cycle it is high pops one word
- data_out  out  WIDTH  head word; 0 when empty
- count  out  ADDR_BITS+1  number of stored words, 0..DEPTH
- underflow  out  1  sticky error flag: ack_to_fifo was seen while empty

## Operation
- Storage:
  - DEPTH x WIDTH memory.
  - wr_ptr and rd_ptr are ADDR_BITS wide and wrap modulo DEPTH.
  - count is kept separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Input FSM, states ARMED and HOLD:
  - ARMED, DIR=1 and count<DEPTH: write data_in at wr_ptr, increment wr_ptr, set ack_from_fifo<=1, go to HOLD.
  - ARMED, DIR=1 and count==DEPTH: stall. No write, no ack, stay in ARMED. Capture happens on the first edge after space frees.
  - ARMED, DIR=0: stay in ARMED.
  - HOLD: ack_from_fifo<=0. Stay in HOLD while DIR=1; go to ARMED once DIR=0 is sampled. A DIR held high for many cycles therefore produces exactly one capture.
- Output side:
  - Pop happens when ack_to_fifo=1 is sampled and count>0: increment rd_ptr.
  - ack_to_fifo=1 while count==0: ignored, and underflow<=1. underflow stays set until reset.
- DOR = (count!=0). data_out = mem[rd_ptr] when count!=0, else 0.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. Fullness is judged on the pre-edge count, so a push at count==DEPTH stalls even if a pop happens in the same cycle.
- Reset (any cycle, mid-transfer included):
  - Pointers=0, count=0, FSM=ARMED.
  - Outputs: ack_from_fifo=0, DOR=0, data_out=0, underflow=0.
  - Stored words are discarded. A word in HOLD is not re-captured unless DIR is still high after reset, because ARMED accepts it.

## Timing
- Capture latency:
  - DIR=1 is sampled at edge E (ARMED, not full).
  - ack_from_fifo is high from E to E+1.
  - DOR and data_out are valid from E if the FIFO was empty. That is one edge of latency, with no combinational path from DIR to DOR.
- Maximum input rate is one word per 2 cycles: DIR high at E, low sampled at E+1, next capture at E+2.
- Pop:
  - ack_to_fifo sampled high at edge P removes the head.
  - DOR and data_out show the next word, or the empty state, from P.
  - A consumer that acks, drops ack, and re-samples DOR one cycle later never double-pops.
- count, DOR and underflow are registered. data_out is a memory read of registered state.

## Test plan
- Reset released; DIR=1 with data_in=42 for 3 cycles, then 0.
  - Exactly one ack_from_fifo pulse; DOR=1, data_out=42, count=1.
  - Consumer acks once: DOR=0, data_out=0.
- Push 10, 11, 12, 13 with no acks: count=4. Push 14 with DIR held:
  - No ack while full.
  - One ack_to_fifo pulse pops 10, and 14 is captured on the next edge (count=4).
  - Draining then yields 11, 12, 13, 14.
- Push 7 words with interleaved pops (pointer wrap): output order equals input order, and count never exceeds 4.
- count=1 (head 5). Push 6 and ack in the same cycle: count stays 1, data_out=6.
- Empty FIFO, pulse ack_to_fifo: underflow=1 and stays 1 through later traffic; count stays 0.
- count=3, FSM in HOLD, assert reset for 1 cycle:
  - All outputs are 0 after the edge.
  - If DIR is still high with 99, then 99 is captured on the first post-reset edge and count=1.
